// File: rtl/gray_conv_pkg.sv
// Shared types and reference conversions for the Gray/binary pipeline.
// Reference functions operate on 64-bit zero-extended words.
package gray_conv_pkg;

    typedef enum logic {GC_G2B = 1'b0, GC_B2G = 1'b1} gc_mode_t;

    localparam int GC_REF_W = 64;

    function automatic int gc_stages(input int width);
        return $clog2(width);
    endfunction

    function automatic logic [GC_REF_W-1:0] gray2bin(input logic [GC_REF_W-1:0] g);
        logic [GC_REF_W-1:0] b;
        b[GC_REF_W-1] = g[GC_REF_W-1];
        for (int i = GC_REF_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GC_REF_W-1:0] bin2gray(input logic [GC_REF_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One register slice of the converter: XOR with a SHIFT-ed copy (always in the first slice, G2B only later).
// Latency: 1 cycle. Backpressure: loads when empty or when downstream loads, otherwise holds everything.
// With GRAY_CONV_CHECK_EN defined the slice also carries the original input word.
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter bit FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld_i,
    input  logic             up_mode_i,
    input  logic [WIDTH-1:0] up_dat_i,
`ifdef GRAY_CONV_CHECK_EN
    input  logic [WIDTH-1:0] up_orig_i,
    output logic [WIDTH-1:0] orig_o,
`endif
    input  logic             dn_load_i,
    output logic             load_o,
    output logic             vld_o,
    output logic             mode_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q, vld_d;
    gc_mode_t         mode_q, mode_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic [WIDTH-1:0] xform;
`ifdef GRAY_CONV_CHECK_EN
    logic [WIDTH-1:0] orig_q, orig_d;
`endif

    assign load_o = !vld_q || dn_load_i;

    // Binary->Gray is finished after the first slice; later slices just carry it.
    always_comb begin
        xform = up_dat_i;
        if (FIRST || gc_mode_t'(up_mode_i) == GC_G2B) begin
            xform = up_dat_i ^ (up_dat_i >> SHIFT);
        end
    end

    // Empty loads clear data so nothing undefined ever reaches the output.
    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        dat_d  = dat_q;
`ifdef GRAY_CONV_CHECK_EN
        orig_d = orig_q;
`endif
        if (load_o) begin
            vld_d  = up_vld_i;
            mode_d = up_vld_i ? gc_mode_t'(up_mode_i) : GC_G2B;
            dat_d  = up_vld_i ? xform : '0;
`ifdef GRAY_CONV_CHECK_EN
            orig_d = up_vld_i ? up_orig_i : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            mode_q <= GC_G2B;
            dat_q  <= '0;
`ifdef GRAY_CONV_CHECK_EN
            orig_q <= '0;
`endif
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            dat_q  <= dat_d;
`ifdef GRAY_CONV_CHECK_EN
            orig_q <= orig_d;
`endif
        end
    end

    assign vld_o  = vld_q;
    assign mode_o = mode_q;
    assign dat_o  = dat_q;
`ifdef GRAY_CONV_CHECK_EN
    assign orig_o = orig_q;
`endif

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined Gray<->binary converter, one prefix-XOR step per slice; optional out_err via GRAY_CONV_CHECK_EN.
// Latency: $clog2(WIDTH) register slices. Backpressure: bubble-collapsing, in_ready combinational from out_ready.
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef GRAY_CONV_CHECK_EN
    output logic             out_mode,
    output logic             out_err
`else
    output logic             out_mode
`endif
);

    localparam int STAGES = gc_stages(WIDTH);

    for (genvar j = 0; j < STAGES; j++) begin : g_st
        logic             up_vld, up_mode, nxt_ld;
        logic [WIDTH-1:0] up_dat;
        logic             ld, vld, mode;
        logic [WIDTH-1:0] dat;
`ifdef GRAY_CONV_CHECK_EN
        logic [WIDTH-1:0] up_orig, orig;
`endif

        if (j == 0) begin : g_head
            assign up_vld  = in_valid;
            assign up_mode = in_mode;
            assign up_dat  = in_data;
`ifdef GRAY_CONV_CHECK_EN
            assign up_orig = in_data;
`endif
        end else begin : g_link
            assign up_vld  = g_st[j-1].vld;
            assign up_mode = g_st[j-1].mode;
            assign up_dat  = g_st[j-1].dat;
`ifdef GRAY_CONV_CHECK_EN
            assign up_orig = g_st[j-1].orig;
`endif
        end

        if (j == STAGES - 1) begin : g_tail
            assign nxt_ld = out_ready;
        end else begin : g_mid
            assign nxt_ld = g_st[j+1].ld;
        end

        gray_conv_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << j),
            .FIRST (j == 0)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_vld_i  (up_vld),
            .up_mode_i (up_mode),
            .up_dat_i  (up_dat),
`ifdef GRAY_CONV_CHECK_EN
            .up_orig_i (up_orig),
            .orig_o    (orig),
`endif
            .dn_load_i (nxt_ld),
            .load_o    (ld),
            .vld_o     (vld),
            .mode_o    (mode),
            .dat_o     (dat)
        );
    end

    assign in_ready  = g_st[0].ld;
    assign out_valid = g_st[STAGES-1].vld;
    assign out_mode  = g_st[STAGES-1].mode;
    assign out_data  = g_st[STAGES-1].dat;

`ifdef GRAY_CONV_CHECK_EN
    function automatic logic [WIDTH-1:0] g2b_w(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Convert the result back the other way; it must reproduce the word that entered.
    logic [WIDTH-1:0] reenc;
    always_comb begin
        reenc = out_data ^ (out_data >> 1);
        if (gc_mode_t'(out_mode) == GC_B2G) begin
            reenc = g2b_w(out_data);
        end
    end

    assign out_err = out_valid && (reenc != g_st[STAGES-1].orig);
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Bench for gray_conv_pipe: WIDTH=32 and WIDTH=5 instances, vector table plus randomized scoreboard runs.
module tb_gray_conv_pipe;
    import gray_conv_pkg::*;

    localparam int W  = 32;
    localparam int S  = 5;
    localparam int W5 = 5;
    localparam int S5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_iv, a_ir, a_im, a_ov, a_or, a_om;
    logic [W-1:0]  a_id, a_od;
    logic          b_iv, b_ir, b_im, b_ov, b_or, b_om;
    logic [W5-1:0] b_id, b_od;
`ifdef GRAY_CONV_CHECK_EN
    logic          a_err, b_err;
`endif

    gray_conv_pipe #(.WIDTH(W)) u32 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_mode(a_im),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
`ifdef GRAY_CONV_CHECK_EN
        .out_err(a_err),
`endif
        .out_mode(a_om)
    );

    gray_conv_pipe #(.WIDTH(W5)) u5 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_mode(b_im),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
`ifdef GRAY_CONV_CHECK_EN
        .out_err(b_err),
`endif
        .out_mode(b_om)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bit i of the binary value is the parity of Gray bits i..w-1.
    function automatic logic [31:0] ref_conv(input logic mode, input logic [31:0] d, input int w);
        logic [31:0] r, m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        d = d & m;
        r = '0;
        if (mode) r = (d ^ (d >> 1)) & m;
        else for (int i = 0; i < w; i++) r[i] = ^(d >> i);
        return r;
    endfunction

    typedef struct {
        logic        w5;
        logic        mode;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        mode;
        logic [31:0] d;
    } item_t;

    item_t       sbq[$];
    logic        pv_stall = 1'b0;
    logic [31:0] pv_d;
    logic        pv_m;
    logic        acc;

    // One clock of the WIDTH=32 scoreboard: sample at negedge, then advance past the next posedge.
    task automatic tick();
        item_t it;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            chk("in_ready vs occupancy", a_ir, (sbq.size() < S) || a_or);
            if (!a_ov) chk("idle out_data", {a_om, a_od}, 0);
            if (pv_stall) chk("stall hold", {a_ov, a_om, a_od}, {1'b1, pv_m, pv_d});
`ifdef GRAY_CONV_CHECK_EN
            chk("out_err", a_err, 0);
`endif
            if (a_ov && a_or) begin
                n_pop++;
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected output: got %0h expected none", a_od);
                end else begin
                    it = sbq.pop_front();
                    chk("stream data", a_od, ref_conv(it.mode, it.d, W));
                    chk("stream mode", a_om, it.mode);
                end
            end
            if (a_iv && a_ir) begin
                sbq.push_back('{a_im, a_id});
                acc = 1'b1;
            end
            pv_stall = a_ov && !a_or;
            pv_d     = a_od;
            pv_m     = a_om;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sbq.delete();
            pv_stall = 1'b0;
        end
    endtask

    // Single word through an idle pipe with out_ready high; checks latency, data and mode.
    task automatic run_one(input logic w5, input logic mode, input logic [31:0] din,
                           input logic [31:0] exp, input string tag);
        int          n;
        logic        got_v;
        logic [31:0] od;
        logic        om;
        if (w5) begin b_iv = 1'b1; b_im = mode; b_id = din[4:0]; b_or = 1'b1; end
        else    begin a_iv = 1'b1; a_im = mode; a_id = din;      a_or = 1'b1; end
        @(negedge clk);
        chk({tag, " in_ready"}, w5 ? b_ir : a_ir, 1);
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        b_iv = 1'b0;
        got_v = 1'b0;
        for (n = 0; n <= 20; n++) begin
            @(negedge clk);
            got_v = w5 ? b_ov : a_ov;
            if (got_v) break;
            @(posedge clk);
            #1;
        end
        od = w5 ? {27'b0, b_od} : a_od;
        om = w5 ? b_om : a_om;
        chk({tag, " latency"}, n, w5 ? S5 - 1 : S - 1);
        chk({tag, " data"}, od, exp);
        chk({tag, " mode"}, om, mode);
        @(posedge clk);
        #1;
    endtask

    vec_t vt[6];

    initial begin
        logic [63:0] r64;
        logic [31:0] ev;
        int          sent;
        int          pops0;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0000_0002};
        vt[1] = '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF};
        vt[2] = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0007};
        vt[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
        vt[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_001F};
        vt[5] = '{1'b1, 1'b0, 32'h0000_000D, 32'h0000_0009};

        rst = 1'b1;
        a_iv = 1'b0; a_im = 1'b0; a_id = '0; a_or = 1'b0;
        b_iv = 1'b0; b_im = 1'b0; b_id = '0; b_or = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", a_ov, 0);
        chk("reset out_data", a_od, 0);
        chk("reset out_mode", a_om, 0);
        chk("reset in_ready", a_ir, 1);
        chk("reset w5 out_valid", b_ov, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_one(vt[i].w5, vt[i].mode, vt[i].din, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Exhaustive WIDTH=5 sweep against the package functions.
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 32; c++) begin
                r64 = (m == 1) ? bin2gray(64'(c)) : gray2bin(64'(c));
                ev  = {27'b0, r64[4:0]};
                run_one(1'b1, m[0], 32'(c), ev, $sformatf("sweep m%0d c%0d", m, c));
            end
        end

        // Backpressure: out_ready low, offer 8 words.
        a_or = 1'b0;
        sent = 0;
        pops0 = n_pop;
        a_id = $urandom;
        a_im = 1'b0;
        for (int c = 0; c < 10; c++) begin
            a_iv = 1'b1;
            tick();
            if (acc) begin
                sent++;
                a_id = $urandom;
                a_im = sent[0];
            end
        end
        chk("bp accepts while stalled", sent, S);
        chk("bp in_ready low", a_ir, 0);
        a_or = 1'b1;
        for (int c = 0; c < 60; c++) begin
            a_iv = (sent < 8);
            tick();
            if (acc) begin
                sent++;
                a_id = $urandom;
                a_im = sent[0];
            end
            if (sent == 8 && sbq.size() == 0) break;
        end
        chk("bp words sent", sent, 8);
        chk("bp words emerged", n_pop - pops0, 8);
        chk("bp drained", sbq.size(), 0);

        // Bubbles: in_valid toggles, out_ready random.
        a_iv = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            a_iv = ~a_iv;
            a_id = $urandom;
            a_im = 1'($urandom_range(0, 1));
            a_or = 1'($urandom_range(0, 1));
            tick();
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sbq.size() == 0) break;
            tick();
        end
        chk("bubble drained", sbq.size(), 0);

        // Reset with three words in flight.
        a_or = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a_iv = 1'b1;
            a_id = $urandom;
            a_im = 1'($urandom_range(0, 1));
            tick();
        end
        chk("pre-reset in flight", sbq.size(), 3);
        a_iv = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        chk("post-reset out_valid", a_ov, 0);
        chk("post-reset out_data", a_od, 0);
        chk("post-reset in_ready", a_ir, 1);
        pops0 = n_pop;
        a_or = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("no ghost after reset", n_pop - pops0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
